button_counter: RTL and testbench

BUTTON_COUNTER -- requirements
Module: button_counter

---
 rtl/button_counter.sv | 137 +++++++++++++
 tb/tb_button_counter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_counter.sv
// Two debounced push-buttons drive a 4-bit up/down counter with parallel load.
// A 'wrap' pulse marks the 15<->0 rollover.

module button_counter_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic press_o,
  output logic busy_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          db_q;
  logic          db_d;
  logic          db_prev_q;
  logic          press_q;
  logic          press_d;
  logic [CW-1:0] dcnt_q;
  logic [CW-1:0] dcnt_d;

  // Any sample that agrees with the accepted level restarts the qualification window.
  always_comb begin
    db_d   = db_q;
    dcnt_d = '0;
    if (s2_q != db_q) begin
      if (dcnt_q == TC) begin
        db_d   = s2_q;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
    press_d = db_prev_q & ~db_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      db_q      <= 1'b1;
      db_prev_q <= 1'b1;
      dcnt_q    <= '0;
      press_q   <= 1'b0;
    end else begin
      s1_q      <= btn_n_i;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      dcnt_q    <= dcnt_d;
      press_q   <= press_d;
    end
  end

  assign press_o = press_q;
  assign busy_o  = (s2_q != db_q);

endmodule

module button_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       load_en,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       wrap,
  output logic       busy
);

  logic       up_press;
  logic       dn_press;
  logic       up_busy;
  logic       dn_busy;
  logic [3:0] count_q;
  logic [3:0] count_d;
  logic       wrap_q;
  logic       wrap_d;

  button_counter_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_up (
    .clk_i  (clk),
    .rst_i  (rst),
    .btn_n_i(btn_up_n),
    .press_o(up_press),
    .busy_o (up_busy)
  );

  button_counter_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_dn (
    .clk_i  (clk),
    .rst_i  (rst),
    .btn_n_i(btn_down_n),
    .press_o(dn_press),
    .busy_o (dn_busy)
  );

  // Load beats presses; simultaneous up and down cancel out.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load_en) begin
      count_d = load_val;
    end else if (up_press && !dn_press) begin
      count_d = count_q + 4'd1;
      wrap_d  = (count_q == 4'hF);
    end else if (dn_press && !up_press) begin
      count_d = count_q - 4'd1;
      wrap_d  = (count_q == 4'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'h0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign busy  = up_busy | dn_busy;

endmodule

// File: tb/tb_button_counter.sv
// Directed bench for button_counter with the default debounce length of 4.
// Inputs change and outputs are sampled 1ns after the rising edge.

module tb_button_counter;

  logic       clk;
  logic       rst;
  logic       btn_up_n;
  logic       btn_down_n;
  logic       load_en;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       wrap;
  logic       busy;

  int checks;
  int failures;
  int wraps_seen;

  button_counter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up_n  (btn_up_n),
    .btn_down_n(btn_down_n),
    .load_en   (load_en),
    .load_val  (load_val),
    .count     (count),
    .wrap      (wrap),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (wrap === 1'b1) wraps_seen++;
    end
  endtask

  // Button low long enough to be accepted (count moves on the 8th edge), then released and settled.
  task automatic do_press(input bit up, input bit dn);
    if (up) btn_up_n = 1'b0;
    if (dn) btn_down_n = 1'b0;
    tick(8);
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    tick(8);
  endtask

  task automatic do_load(input logic [3:0] v);
    load_en  = 1'b1;
    load_val = v;
    tick(1);
    load_en  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; btn_up_n = 1'b1; btn_down_n = 1'b1;
    load_en = 1'b1; load_val = 4'd7;
    tick(2);
    load_en = 1'b0;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    tick(2);
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL post_reset_count got=%0d exp=0", count); end
  endtask

  task automatic test_hold_up;
    wraps_seen = 0;
    btn_up_n = 1'b0;
    tick(3);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy_pending got=%b exp=1", busy); end
    tick(4);
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL hold_count_e6 got=%0d exp=0", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_busy_accepted got=%b exp=0", busy); end
    tick(1);
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL hold_count_e7 got=%0d exp=1", count); end
    tick(42);
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL hold_no_repeat got=%0d exp=1", count); end
    checks++; if (wraps_seen !== 0) begin failures++; $display("FAIL hold_wrap got=%0d exp=0", wraps_seen); end
    btn_up_n = 1'b1;
    tick(10);
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL release_no_event got=%0d exp=1", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_glitch;
    wraps_seen = 0;
    btn_down_n = 1'b0;
    tick(2);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy got=%b exp=1", busy); end
    tick(1);
    btn_down_n = 1'b1;
    tick(10);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_clear got=%b exp=0", busy); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL glitch_count got=%0d exp=1", count); end
    checks++; if (wraps_seen !== 0) begin failures++; $display("FAIL glitch_wrap got=%0d exp=0", wraps_seen); end
  endtask

  task automatic test_wrap;
    do_load(4'd15);
    checks++; if (count !== 4'd15) begin failures++; $display("FAIL load15 got=%0d exp=15", count); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL load15_wrap got=%b exp=0", wrap); end
    wraps_seen = 0;
    do_press(1'b1, 1'b0);
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL wrap_up_count got=%0d exp=0", count); end
    checks++; if (wraps_seen !== 1) begin failures++; $display("FAIL wrap_up_pulses got=%0d exp=1", wraps_seen); end
    wraps_seen = 0;
    do_press(1'b0, 1'b1);
    checks++; if (count !== 4'd15) begin failures++; $display("FAIL wrap_dn_count got=%0d exp=15", count); end
    checks++; if (wraps_seen !== 1) begin failures++; $display("FAIL wrap_dn_pulses got=%0d exp=1", wraps_seen); end
    do_load(4'd6);
    wraps_seen = 0;
    do_press(1'b0, 1'b1);
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL dec_count got=%0d exp=5", count); end
    checks++; if (wraps_seen !== 0) begin failures++; $display("FAIL dec_wrap got=%0d exp=0", wraps_seen); end
  endtask

  task automatic test_simultaneous;
    do_load(4'd3);
    wraps_seen = 0;
    do_press(1'b1, 1'b1);
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL both_count got=%0d exp=3", count); end
    checks++; if (wraps_seen !== 0) begin failures++; $display("FAIL both_wrap got=%0d exp=0", wraps_seen); end
    do_load(4'd15);
    wraps_seen = 0;
    btn_up_n = 1'b0;
    tick(7);
    load_en  = 1'b1;
    load_val = 4'd9;
    tick(1);
    load_en  = 1'b0;
    checks++; if (count !== 4'd9) begin failures++; $display("FAIL load_prio_count got=%0d exp=9", count); end
    tick(5);
    btn_up_n = 1'b1;
    tick(8);
    checks++; if (count !== 4'd9) begin failures++; $display("FAIL load_prio_discard got=%0d exp=9", count); end
    checks++; if (wraps_seen !== 0) begin failures++; $display("FAIL load_prio_wrap got=%0d exp=0", wraps_seen); end
  endtask

  task automatic test_sixteen;
    logic [3:0] exp_cnt;
    do_load(4'd5);
    exp_cnt    = 4'd5;
    wraps_seen = 0;
    for (int i = 0; i < 16; i++) begin
      do_press(1'b1, 1'b0);
      exp_cnt = exp_cnt + 4'd1;
      checks++; if (count !== exp_cnt) begin failures++; $display("FAIL sixteen_step%0d got=%0d exp=%0d", i, count, exp_cnt); end
    end
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL sixteen_final got=%0d exp=5", count); end
    checks++; if (wraps_seen !== 1) begin failures++; $display("FAIL sixteen_wraps got=%0d exp=1", wraps_seen); end
  endtask

  task automatic test_reset_mid_debounce;
    btn_up_n = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    tick(1);
    rst = 1'b0;
    wraps_seen = 0;
    tick(7);
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rst_fresh_e6 got=%0d exp=0", count); end
    tick(1);
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL rst_fresh_e7 got=%0d exp=1", count); end
    tick(20);
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL rst_fresh_single got=%0d exp=1", count); end
    btn_up_n = 1'b1;
    tick(8);
    checks++; if (wraps_seen !== 0) begin failures++; $display("FAIL rst_fresh_wrap got=%0d exp=0", wraps_seen); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    wraps_seen = 0;
    rst        = 1'b1;
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    load_en    = 1'b0;
    load_val   = 4'd0;
    test_reset();
    test_hold_up();
    test_glitch();
    test_wrap();
    test_simultaneous();
    test_sixteen();
    test_reset_mid_debounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
